// File: rtl/iir_pkg.sv
// Shared types, widths and the round/saturate helper for the inverse biquad.
package iir_pkg;

  localparam int DATA_BIT_NUM  = 16;
  localparam int COEFF_BIT_NUM = 16;
  localparam int COEFF_FRAC    = 14;
  localparam int PROD_W        = DATA_BIT_NUM + COEFF_BIT_NUM;
  localparam int ACC_W         = DATA_BIT_NUM + COEFF_BIT_NUM + 3;

  localparam logic signed [COEFF_BIT_NUM-1:0] COEFF_ONE = COEFF_BIT_NUM'(2**COEFF_FRAC);

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2**(COEFF_FRAC-1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(2**(DATA_BIT_NUM-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = -SAT_MAX - ACC_W'(1);

  localparam logic [2:0] TAP_LAST = 3'd4;
  localparam logic [2:0] TAP_DONE = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Round half up, then clamp to the sample range.
  function automatic logic [DATA_BIT_NUM-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + ROUND_HALF) >>> COEFF_FRAC;
    if (r > SAT_MAX)
      return SAT_MAX[DATA_BIT_NUM-1:0];
    else if (r < SAT_MIN)
      return SAT_MIN[DATA_BIT_NUM-1:0];
    else
      return r[DATA_BIT_NUM-1:0];
  endfunction

endpackage

// File: rtl/iir_inverse_biquad_mac.sv
// Shared signed multiply-accumulator; subtract mode avoids negating a coefficient.
module iir_mac_unit
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_sub,
  input  logic [DATA_BIT_NUM-1:0]  i_data,
  input  logic [COEFF_BIT_NUM-1:0] i_coeff,
  output logic [ACC_W-1:0]         o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod     = $signed(i_data) * $signed(i_coeff);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/iir_inverse_biquad.sv
// Inverse biquad: recovers x[n] from y[n] with one time-multiplexed MAC over 5 taps.
// state | meaning
// IDLE  | waiting for an input sample, in_ready high
// MAC   | taps 0..4 accumulate, tap 5 commits result and history
// OUT   | result presented until out_ready
module iir_inverse_biquad
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [COEFF_BIT_NUM-1:0] coeff_in_2,
  input  logic [COEFF_BIT_NUM-1:0] coeff_in_3,
  input  logic [COEFF_BIT_NUM-1:0] coeff_out_1,
  input  logic [COEFF_BIT_NUM-1:0] coeff_out_2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BIT_NUM-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BIT_NUM-1:0]  out_data
);

  state_t r_state;
  state_t w_next;
  logic [2:0] r_tap;

  logic [DATA_BIT_NUM-1:0]  r_in, r_in1, r_in2, r_out1, r_out2, r_out_data;
  logic [COEFF_BIT_NUM-1:0] r_b1, r_b2, r_a1, r_a2;

  logic                     w_flush;
  logic                     w_accept;
  logic                     w_commit;
  logic                     w_mac_en;
  logic                     w_sub;
  logic [DATA_BIT_NUM-1:0]  w_op_data;
  logic [COEFF_BIT_NUM-1:0] w_op_coeff;
  logic [ACC_W-1:0]         w_acc;
  logic [DATA_BIT_NUM-1:0]  w_result;

  assign w_flush  = rst || clear;
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_commit = (r_state == MAC) && (r_tap == TAP_DONE);
  assign w_mac_en = (r_state == MAC) && (r_tap <= TAP_LAST);
  assign w_result = sat_round($signed(w_acc));

  always_ff @(posedge clk) begin
    if (w_flush)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = MAC;
      MAC:     if (r_tap == TAP_DONE) w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_flush || w_accept)
      r_tap <= '0;
    else if (r_state == MAC)
      r_tap <= r_tap + 3'd1;
  end

  // Coefficients are frozen for the whole MAC pass.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_in <= in_data;
      r_b1 <= coeff_in_2;
      r_b2 <= coeff_in_3;
      r_a1 <= coeff_out_1;
      r_a2 <= coeff_out_2;
    end
  end

  always_comb begin
    w_op_data  = r_in;
    w_op_coeff = COEFF_ONE;
    w_sub      = 1'b0;
    case (r_tap)
      3'd1: begin w_op_data = r_in1;  w_op_coeff = r_a1; w_sub = 1'b1; end
      3'd2: begin w_op_data = r_in2;  w_op_coeff = r_a2; w_sub = 1'b1; end
      3'd3: begin w_op_data = r_out1; w_op_coeff = r_b1; w_sub = 1'b1; end
      3'd4: begin w_op_data = r_out2; w_op_coeff = r_b2; w_sub = 1'b1; end
      default: ;
    endcase
  end

  iir_mac_unit u_mac (
    .clk     (clk),
    .rst     (w_flush),
    .i_clr   (w_accept),
    .i_en    (w_mac_en),
    .i_sub   (w_sub),
    .i_data  (w_op_data),
    .i_coeff (w_op_coeff),
    .o_acc   (w_acc)
  );

  // History advances once per sample, on the commit cycle only.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_in1      <= '0;
      r_in2      <= '0;
      r_out1     <= '0;
      r_out2     <= '0;
      r_out_data <= '0;
    end else if (w_commit) begin
      r_in2      <= r_in1;
      r_in1      <= r_in;
      r_out2     <= r_out1;
      r_out1     <= w_result;
      r_out_data <= w_result;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign out_data  = r_out_data;

endmodule
